// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared types and helpers for the UART
// transmit scheduler.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } sched_state_t;

  localparam int NUM_REQ = 2;

  // Bits needed to hold CHAR_CYCLES-2 (at least one bit).
  function automatic int gap_width(input int cycles);
    if (cycles > 2)
      return $clog2(cycles - 1);
    return 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO with show-ahead head
// and occupancy count.
module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   sys_clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   rd_en,
  output logic [7:0]             rd_data,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage write; contents need no reset.
  always_ff @(posedge sys_clk) begin
    if (wr_en)
      mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally; level tracks push/pop.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + AW'(1);
      if (rd_en)
        rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin merge of two byte producers
// into one paced UART transmit strobe stream.
module uart_tx_scheduler #(
  parameter int FIFO_DEPTH  = 8,
  parameter int CHAR_CYCLES = 2344
) (
  input  logic                          sys_clk,
  input  logic                          rst_n,
  input  logic [7:0]                    req0_data,
  input  logic                          req0_valid,
  output logic                          req0_ready,
  input  logic [7:0]                    req1_data,
  input  logic                          req1_valid,
  output logic                          req1_ready,
  output logic [7:0]                    tx_data,
  output logic                          tx_en,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  import uart_sched_pkg::*;

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int GW = gap_width(CHAR_CYCLES);
  localparam logic [GW-1:0] GAP_LOAD = GW'(CHAR_CYCLES - 2);

  sched_state_t       state;
  logic [GW-1:0]      gap;
  logic               last_grant;
  logic [NUM_REQ-1:0] grant;
  logic               room;
  logic               push;
  logic               pop;
  logic [7:0]         push_data;
  logic [7:0]         head;

  // Registered occupancy only: a same-cycle pop never frees a slot.
  assign room = rst_n && (fifo_level < LW'(FIFO_DEPTH));

  assign grant[0] = room && req0_valid &&
                    (!req1_valid || last_grant);
  assign grant[1] = room && req1_valid &&
                    (!req0_valid || !last_grant);

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  assign push      = |grant;
  assign push_data = grant[1] ? req1_data : req0_data;
  assign pop       = (state == IDLE) && (fifo_level != '0);
  assign busy      = (fifo_level != '0) || (state != IDLE);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (push_data),
    .rd_en   (pop),
    .rd_data (head),
    .level   (fifo_level)
  );

  // Remember the last winner so ties alternate.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)
      last_grant <= 1'b1;
    else if (grant[0])
      last_grant <= 1'b0;
    else if (grant[1])
      last_grant <= 1'b1;
  end

  // Pacing engine: one strobe, then hold off for the gap.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gap     <= '0;
      tx_en   <= 1'b0;
      tx_data <= '0;
    end else begin
      tx_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            tx_data <= head;
            tx_en   <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          gap   <= GAP_LOAD;
          state <= (CHAR_CYCLES > 2) ? GAP : IDLE;
        end
        GAP: begin
          gap <= gap - GW'(1);
          if (gap <= GW'(1))
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed stimulus with a byte-order
// scoreboard and pacing/arbitration checks.
module tb_uart_tx_scheduler;

  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req0_data = '0;
  logic       req0_valid = 1'b0;
  logic       req0_ready;
  logic [7:0] req1_data = '0;
  logic       req1_valid = 1'b0;
  logic       req1_ready;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       busy;
  logic [2:0] fifo_level;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int dual_ready = 0;
  int over_full = 0;

  logic [7:0] exp_q[$];
  int         pulses[$];
  int         grants[$];

  uart_tx_scheduler #(
    .FIFO_DEPTH  (4),
    .CHAR_CYCLES (10)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .req0_data  (req0_data),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req1_data  (req1_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .tx_data    (tx_data),
    .tx_en      (tx_en),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act === exp)
      passes++;
    else
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
  endtask

  // Handshake observer: grant log and protocol invariants.
  always @(negedge sys_clk) begin
    if (req0_valid && req0_ready) grants.push_back(0);
    if (req1_valid && req1_ready) grants.push_back(1);
    if (req0_ready && req1_ready) dual_ready++;
    if (fifo_level > 3'd4) over_full++;
  end

  // Output monitor: pops the scoreboard on every strobe.
  always @(negedge sys_clk) begin
    if (tx_en === 1'b1) begin
      pulses.push_back(cyc);
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_tx: got %02h expected none",
                 tx_data);
      end else begin
        check("tx_data_order", tx_data, exp_q.pop_front());
      end
    end
  end

  task automatic send(input int r, input logic [7:0] d,
                      output int hs);
    bit acc = 1'b0;
    hs = -1;
    if (r == 0) begin
      req0_data = d; req0_valid = 1'b1;
    end else begin
      req1_data = d; req1_valid = 1'b1;
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      if ((r == 0 && req0_ready) || (r == 1 && req1_ready)) begin
        acc = 1'b1;
        hs = cyc;
        break;
      end
    end
    @(posedge sys_clk); #1;
    if (r == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
    if (!acc) begin
      checks++;
      $display("FAIL send_timeout: req%0d byte %02h got no ready expected accept",
               r, d);
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge sys_clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++;
      $display("FAIL %s: got busy=1 expected busy=0", name);
    end
    @(posedge sys_clk); #1;
  endtask

  task automatic wait_until(input int t);
    for (int i = 0; i < 1000 && cyc < t; i++) begin
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1 rst_n = 1'b1;
    @(posedge sys_clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, h, fall, pc0;
    int exp_g[8];
    exp_g = '{0, 1, 0, 1, 0, 1, 0, 1};

    // Reset state, with a requester already valid.
    req0_valid = 1'b1;
    req0_data  = 8'h99;
    #12;
    check("rst_tx_en", tx_en, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ready0", req0_ready, 0);
    req0_valid = 1'b0;
    @(posedge sys_clk); #1 rst_n = 1'b1;
    @(posedge sys_clk); #1;

    // Single byte latency and gap.
    exp_q.push_back(8'h41);
    pc0 = pulse_cnt;
    req0_data = 8'h41; req0_valid = 1'b1;
    @(negedge sys_clk);
    check("single_ready", req0_ready, 1);
    n = cyc;
    @(posedge sys_clk); #1 req0_valid = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    check("single_tx_en_n2", tx_en, 1);
    check("single_tx_data", tx_data, 8'h41);
    fall = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge sys_clk);
      if (!busy) begin fall = cyc; break; end
    end
    check("busy_fall_cycle", fall, n + 11);
    repeat (20) @(posedge sys_clk);
    #1;
    check("single_pulse_count", pulse_cnt - pc0, 1);

    // Back-to-back pacing from one requester.
    pulses.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h30 + 8'(i));
    for (int i = 0; i < 4; i++) send(0, 8'h30 + 8'(i), h);
    wait_idle("pace_drain");
    check("pace_pulse_count", pulses.size(), 4);
    for (int i = 1; i < 4; i++)
      if (pulses.size() > i)
        check("pace_spacing", pulses[i] - pulses[i-1], 10);

    // Fairness with both valid; FIFO fills while in GAP.
    do_reset();
    grants.delete();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'hAA);
      exp_q.push_back(8'h55);
    end
    fork
      for (int i = 0; i < 4; i++) send(0, 8'hAA, h);
      begin
        int h1;
        for (int i = 0; i < 4; i++) send(1, 8'h55, h1);
      end
      begin
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
          @(negedge sys_clk);
          if (fifo_level == 3'd4) begin seen = 1'b1; break; end
        end
        check("fifo_full_reached", seen, 1);
        if (seen) begin
          check("full_ready0", req0_ready, 0);
          check("full_ready1", req1_ready, 0);
        end
      end
    join
    wait_idle("fair_drain");
    check("grant_count", grants.size(), 8);
    for (int i = 0; i < 8; i++)
      if (grants.size() > i)
        check("grant_order", grants[i], exp_g[i]);

    // Push coinciding with an IDLE pop at level 2.
    do_reset();
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h13);
    send(0, 8'h10, n);
    wait_until(n + 3);
    send(0, 8'h11, h);
    send(0, 8'h12, h);
    wait_until(n + 11);
    req1_data = 8'h13; req1_valid = 1'b1;
    @(negedge sys_clk);
    check("pp_ready1", req1_ready, 1);
    check("pp_level_before", fifo_level, 2);
    @(posedge sys_clk); #1 req1_valid = 1'b0;
    @(negedge sys_clk);
    check("pp_level_after", fifo_level, 2);
    wait_idle("pp_drain");

    // Reset mid-GAP with three bytes queued.
    do_reset();
    exp_q.push_back(8'h20);
    send(0, 8'h20, n);
    send(0, 8'h21, h);
    send(0, 8'h22, h);
    send(0, 8'h23, h);
    check("mid_gap_level", fifo_level, 3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_en", tx_en, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_busy", busy, 0);
    repeat (2) @(posedge sys_clk);
    #1 rst_n = 1'b1;
    pc0 = pulse_cnt;
    repeat (30) @(posedge sys_clk);
    #1;
    check("post_rst_no_tx", pulse_cnt - pc0, 0);
    check("post_rst_busy", busy, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    check("never_dual_ready", dual_ready, 0);
    check("never_over_full", over_full, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares the single UART transmit path between two byte producers, e.g. the echo path and the CPU console. Round-robin arbitration places accepted bytes into a small FIFO. A pacing engine drains the FIFO as single-cycle tx_en/tx_data strobes into the uart block's tx_data/tx_en inputs, with at most one byte per character time, because that interface has no transmit-ready feedback.

Parameters:
FIFO_DEPTH, 8, FIFO entries; power of 2, >= 2
CHAR_CYCLES, 2344, minimum sys_clk cycles between tx_en pulses (>= 10 bit times at the configured baud); >= 2

Ports:
sys_clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req0_data  input  8  requester 0 byte
req0_valid  input  1  requester 0 byte available
req0_ready  output  1  requester 0 byte accepted this cycle when valid&ready
req1_data  input  8  requester 1 byte
req1_valid  input  1  requester 1 byte available
req1_ready  output  1  requester 1 byte accepted this cycle when valid&ready
tx_data  output  8  byte to uart block
tx_en  output  1  single-cycle transmit strobe to uart block
busy  output  1  FIFO non-empty or pacing in progress
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset is rst_n, asynchronous, active-low, on clock sys_clk. Reset values: tx_en=0, tx_data=0, busy=0, fifo_level=0, req*_ready=0, state=IDLE, gap counter=0, last_grant=1 (so requester 0 wins the first tie).
- Reset mid-operation discards all queued bytes and any pending pacing. No tx_en is issued until new data arrives.
- Arbitration is combinational from valid inputs and registered state.
  - Grant only when fifo_level < FIFO_DEPTH, using registered occupancy with no same-cycle pop bypass.
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester != last_grant gets ready=1; the other gets ready=0.
  - At most one req*_ready is high per cycle. Ready is never asserted while the FIFO is full.
  - On a handshake (valid&ready), the byte is written to the FIFO and last_grant is updated at the clock edge.
  - Requesters must hold data/valid until accepted. Dropping valid early is legal and is not an error.
- FIFO:
  - Write and read pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - Simultaneous push and pop leaves fifo_level unchanged.
  - Pop when empty never happens, because the engine pops only when non-empty.
- Pacing FSM:
  - IDLE: if fifo_level != 0, pop the head into the tx_data register, go to SEND.
  - SEND: tx_en=1 for exactly this cycle, tx_data stable. Load gap counter with CHAR_CYCLES-2, go to GAP.
  - GAP: decrement each cycle; at 0 go to IDLE.
  - tx_en-to-tx_en spacing is exactly CHAR_CYCLES cycles when the FIFO stays non-empty.
- Latency: a handshake at cycle N into an empty FIFO with the FSM in IDLE gives tx_en high at N+2, with tx_data equal to the byte.
- tx_data holds its value after SEND until the next pop; it is not cleared.
- busy = (fifo_level != 0) | (state != IDLE).
- Ordering: bytes leave in exact acceptance order. Bytes from a single requester are never reordered.

Decomposition:
- Package uart_sched_pkg holds:
  - typedef enum logic [1:0] {IDLE, SEND, GAP} sched_state_t
  - constant for the requester count (2)
  - helper function for the gap counter width
- Sub-module uart_tx_fifo: synchronous FIFO, parameter DEPTH.
  - Ports: sys_clk, rst_n, wr_en, wr_data, rd_en, rd_data, level.
  - rd_data is show-ahead (head always visible).
- Arbiter and pacing FSM live in uart_tx_scheduler.

Test Plan (CHAR_CYCLES=10, FIFO_DEPTH=4 on bench):
- Single byte: req0 sends 0x41 at cycle N -> req0_ready=1 at N; tx_en at N+2 with tx_data=0x41; busy falls after the gap; exactly one tx_en pulse.
- Back-to-back pacing: req0 streams 0x30..0x33 -> tx_en pulses exactly 10 cycles apart, data 0x30,0x31,0x32,0x33 in order.
- Fairness: both valid continuously, req0=0xAA and req1=0x55 -> grants alternate 0,1,0,1,...; output sequence AA,55,AA,55; req0 wins the first tie after reset.
- Full FIFO: both stream while the engine is in GAP -> fifo_level reaches 4, both ready=0 until a pop; no byte lost or duplicated (scoreboard).
- Simultaneous push/pop: push on the same cycle as an IDLE pop at level 2 -> level stays 2.
- Reset mid-GAP with 3 bytes queued: assert rst_n low -> tx_en=0, fifo_level=0, busy=0 immediately; after release, no tx_en until a new handshake.
